seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Parametrised serial pattern detector, the successor to the single-pattern 1-bit FSM demo.
//   Samples one bit per valid cycle and compares the newest PAT_WIDTH bits against PATTERN.
//   Pulses match for one cycle on a hit and keeps a saturating hit count.
//   Selectable overlapping or non-overlapping detection; sits behind the serial input of the demo datapath.
// PARAMETERS
//   PAT_WIDTH  4        pattern length in bits, 2..32
//   PATTERN    4'b1011  target pattern; MSB = earliest received bit
//   OVERLAP    1        1: overlapping hits allowed; 0: window restarts after each hit
//   CNT_WIDTH  8        width of hit counter
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous active-high reset
//   a          in   1          serial data bit
//   a_valid    in   1          a sampled only when 1
//   clr        in   1          synchronous clear of window, fill and count (not config)
//   w          out  1          match pulse, registered
//   hit_cnt    out  CNT_WIDTH  number of matches, saturates at all-ones
//   armed      out  1          1 when PAT_WIDTH bits held since last reset/clr/(non-overlap) hit
// BEHAVIOUR
//   Reset (rst=1 at clk edge): shreg=0, fill=0, state=FILL, w=0, hit_cnt=0, armed=0.
//   Shift: on a_valid, shreg <= {shreg[PAT_WIDTH-2:0], a}; no shift when a_valid=0.
//   fill counter: 0..PAT_WIDTH, increments per valid bit, saturates at PAT_WIDTH.
//   FSM states:
//     FILL  : fill < PAT_WIDTH; w never asserts. -> ARMED when the valid bit makes fill == PAT_WIDTH.
//     ARMED : the window is full; each valid bit is compared.
//   Compare uses the next window value, so the bit that completes the pattern is included.
//   Hit: a_valid=1 and next shreg == PATTERN and fill reaches/holds PAT_WIDTH with that bit.
//   Latency: w=1 on the cycle after the completing a_valid edge, for exactly 1 cycle.
//   w=0 in all cycles without a hit, including a_valid=0 cycles.
//   On a hit, hit_cnt increments in the same edge as w rises.
//     Saturates at {CNT_WIDTH{1'b1}} and does not wrap.
//   OVERLAP=1: state stays ARMED after a hit; bits may be shared between hits.
//   OVERLAP=0: a hit sets fill=0, shreg=0 and state FILL, so the next hit needs PAT_WIDTH new bits.
//   armed = (state == ARMED), registered.
//   clr=1: same effect as rst except that w is forced 0. A bit presented with clr is discarded.
//   Priority: rst > clr > a_valid.
//   Reset or clr during a partial pattern: all partial history is lost and no hit is reported for it.
//   No combinational path from inputs to outputs.
// TESTING
//   T1 reset: rst=1 for 2 cycles with a_valid=1, a toggling -> w=0, hit_cnt=0, armed=0 throughout.
//   T2 overlap (defaults): valid bits 1,0,1,1,0,1,1
//      -> w pulses after bit 4 and after bit 7; hit_cnt=2.
//   T3 non-overlap (OVERLAP=0): same stream -> single w after bit 4; hit_cnt=1; armed=0 after the hit.
//   T4 gaps: bits 1,0,1,1 with a_valid=0 cycles between them -> one w pulse, 1 cycle after the 4th valid edge.
//      No pulse during gap cycles.
//   T5 clr mid-pattern: bits 1,0,1, then clr=1, then 1 -> no hit; armed=0; fill=1.
//   T6 saturation (CNT_WIDTH=2, OVERLAP=1, PATTERN=4'b1111): 1 x 10 bits
//      -> 7 w pulses; hit_cnt holds at 3 and does not wrap.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector. It takes in one bit on each cycle where a_valid
//   is high. It compares the newest PAT_WIDTH bits against PATTERN. A hit
//   produces a registered one-cycle pulse on w. A hit also bumps a saturating
//   hit counter.
//
//   In overlapping mode, consecutive hits may share bits. In non-overlapping
//   mode, the window is emptied after each hit.
//
// Parameters
//   PAT_WIDTH  pattern length in bits (2..32)
//   PATTERN    target pattern; the MSB is the earliest received bit
//   OVERLAP    1: hits may share bits; 0: window restarts after each hit
//   CNT_WIDTH  hit counter width
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   a        serial data bit
//   a_valid  a is sampled only when high
//   clr      synchronous clear of window, fill and count
//   w        registered match pulse (one cycle per hit)
//   hit_cnt  saturating number of hits
//   armed    window holds PAT_WIDTH bits since last reset/clr/restart
module seq_detect_param #(
    parameter int                   PAT_WIDTH = 4,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    input  logic                 a_valid,
    input  logic                 clr,
    output logic                 w,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic                 armed
);

    localparam int             FW    = $clog2(PAT_WIDTH + 1);
    localparam logic [FW-1:0]  FULL  = FW'(PAT_WIDTH);
    localparam logic [0:0]     FILL  = 1'b0;
    localparam logic [0:0]     ARMED = 1'b1;

    logic [PAT_WIDTH-1:0] shreg, shreg_nxt;
    logic [FW-1:0]        fill, fill_nxt;
    logic [0:0]           state;
    logic                 hit;

    // The comparison looks at the window after the incoming bit is shifted in.
    // This way, the bit that completes the pattern counts in the same edge.
    always_comb begin
        shreg_nxt = {shreg[PAT_WIDTH-2:0], a};
        fill_nxt  = (fill == FULL) ? fill : fill + FW'(1);
        hit       = a_valid && (shreg_nxt == PATTERN) && (fill_nxt == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            // clr mirrors reset. A bit presented alongside it is dropped.
            shreg   <= '0;
            fill    <= '0;
            state   <= FILL;
            w       <= 1'b0;
            hit_cnt <= '0;
        end else begin
            w <= hit;
            if (a_valid) begin
                if (hit && (OVERLAP == 1'b0)) begin
                    // Non-overlapping mode: the next hit needs a full set of fresh bits.
                    shreg <= '0;
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    shreg <= shreg_nxt;
                    fill  <= fill_nxt;
                    state <= (fill_nxt == FULL) ? ARMED : FILL;
                end
            end
            if (hit && (hit_cnt != {CNT_WIDTH{1'b1}}))
                hit_cnt <= hit_cnt + CNT_WIDTH'(1);
        end
    end

    assign armed = (state == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst, a, a_valid, clr;
    always #5 clk = ~clk;

    logic [2:0] w_v, armed_v;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    // Three configurations share one input stream:
    // defaults, non-overlap, and a 2-bit counter on pattern 1111.
    seq_detect_param dut_ov (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .clr(clr),
        .w(w_v[0]), .hit_cnt(cnt_ov), .armed(armed_v[0]));
    seq_detect_param #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .clr(clr),
        .w(w_v[1]), .hit_cnt(cnt_no), .armed(armed_v[1]));
    seq_detect_param #(.PATTERN(4'b1111), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .clr(clr),
        .w(w_v[2]), .hit_cnt(cnt_sat), .armed(armed_v[2]));

    typedef struct {
        int   inst;
        logic w;
        int   cnt;
        logic armed;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance
    int m_hist[3], m_n[3], m_cnt[3];
    int m_pat[3]  = '{11, 11, 15};
    int m_ov[3]   = '{1, 0, 1};
    int m_cmax[3] = '{255, 255, 3};
    int sat_pulses;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs.
    // Push the model's expected outputs, then compare them after the edge.
    task automatic step(input logic ia, input logic iv, input logic ic, input logic ir);
        exp_t e;
        a = ia; a_valid = iv; clr = ic; rst = ir;
        for (int k = 0; k < 3; k++) begin
            e.inst = k;
            e.w    = 1'b0;
            if (ir || ic) begin
                m_hist[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
            end else if (iv) begin
                m_hist[k] = ((m_hist[k] << 1) | int'(ia)) & 15;
                if (m_n[k] < 4) m_n[k]++;
                if (m_n[k] == 4 && m_hist[k] == m_pat[k]) begin
                    e.w = 1'b1;
                    if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
                    if (m_ov[k] == 0) begin
                        m_hist[k] = 0; m_n[k] = 0;
                    end
                end
            end
            e.cnt   = m_cnt[k];
            e.armed = (m_n[k] == 4);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            int got_cnt;
            e = sb.pop_front();
            got_cnt = (e.inst == 0) ? int'(cnt_ov) : (e.inst == 1) ? int'(cnt_no) : int'(cnt_sat);
            chk($sformatf("w[%0d]", e.inst), int'(w_v[e.inst]), int'(e.w));
            chk($sformatf("hit_cnt[%0d]", e.inst), got_cnt, e.cnt);
            chk($sformatf("armed[%0d]", e.inst), int'(armed_v[e.inst]), int'(e.armed));
        end
        if (w_v[2]) sat_pulses++;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_hist[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
        end
        sat_pulses = 0;
        // T1: reset held with valid toggling data
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);

        // T2/T3: 1011011
        stream(16'b1011011, 7);
        chk("t2_cnt_ov", int'(cnt_ov), 2);
        chk("t3_cnt_no", int'(cnt_no), 1);
        chk("t3_armed_no", int'(armed_v[1]), 0);

        // T4: 1,0,1,1 with gaps
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_w_ov", int'(w_v[0]), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_w_gap", int'(w_v[0]), 0);

        // T5: 1,0,1 then clr (bit dropped) then 1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        stream(16'b101, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_armed", int'(armed_v[0]), 0);
        chk("t5_cnt", int'(cnt_ov), 0);

        // T6: ten ones into the saturating instance
        step(1'b0, 1'b0, 1'b1, 1'b0);
        sat_pulses = 0;
        stream(16'h03FF, 10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_pulses", sat_pulses, 7);
        chk("t6_cnt_sat", int'(cnt_sat), 3);

        // Random traffic with occasional clear/reset
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
